alu_exec_mdu: RTL

//  Parametrised successor of the single-cycle ALU decoder.

---
 rtl/alu_exec_mdu.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_mdu.sv
// alu_exec_mdu: execute-stage ALU with decode, registered valid/ready result and an
// optional iterative multiply/divide engine.
// Build option: define ALU_EXEC_MDU_EN to include the M-extension engine. Without it,
// M-ops are accepted as single-cycle ops and flagged illegal with a zero result.
module alu_exec_mdu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             funct7b0,
    input  logic             opb5,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_ctrl,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state;
    logic                    accept;
    logic                    is_m;
    logic [3:0]              dec_ctrl;
    logic [WIDTH-1:0]        alu_res;
    logic signed [WIDTH-1:0] src_a_s;
    logic signed [WIDTH-1:0] src_b_s;
    logic [SHAMT_W-1:0]      shamt;

    assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_CALC);
    assign is_m      = opb5 & funct7b0 & alu_op[1];
    assign src_a_s   = src_a;
    assign src_b_s   = src_b;
    assign shamt     = src_b[SHAMT_W-1:0];

    // Decode alu_op/funct fields into the 4-bit ALU control for single-cycle ops
    always_comb begin
        dec_ctrl = 4'b0000;
        if (!alu_op[1]) begin
            dec_ctrl = alu_op[0] ? 4'b0001 : 4'b0000;
        end else begin
            case (funct3)
                3'b000:  dec_ctrl = (opb5 & funct7b5) ? 4'b0001 : 4'b0000;
                3'b001:  dec_ctrl = 4'b0111;
                3'b010:  dec_ctrl = 4'b0101;
                3'b011:  dec_ctrl = 4'b1001;
                3'b100:  dec_ctrl = 4'b0110;
                3'b101:  dec_ctrl = funct7b5 ? 4'b1000 : 4'b0100;
                3'b110:  dec_ctrl = 4'b0011;
                default: dec_ctrl = 4'b0010;
            endcase
        end
    end

    // Single-cycle datapath selected by the decoded control
    always_comb begin
        alu_res = '0;
        case (dec_ctrl)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0110: alu_res = src_a ^ src_b;
            4'b0111: alu_res = src_a << shamt;
            4'b0100: alu_res = src_a >> shamt;
            4'b1000: alu_res = src_a_s >>> shamt;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (src_a_s < src_b_s)};
            4'b1001: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_MDU_EN
    // Two's-complement negate when the sign flag is set (magnitude extract / sign fix)
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Engine state: eng_m holds the multiplicand or divisor magnitude; {eng_hi, eng_lo}
    // is the shifting product (mul) or remainder/quotient pair (div).
    logic [WIDTH-1:0]   eng_m;
    logic [WIDTH-1:0]   eng_hi;
    logic [WIDTH-1:0]   eng_lo;
    logic [WIDTH-1:0]   eng_dvd;
    logic [SHAMT_W-1:0] eng_cnt;
    logic [2:0]         eng_op;
    logic               eng_negq;
    logic               eng_negr;
    logic               eng_dz;

    logic               a_sgn, b_sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   nxt_hi, nxt_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   m_res;
    logic               last;

    // Operand signedness per M-op and magnitude extraction at accept
    always_comb begin
        if (funct3[2]) begin
            a_sgn = ~funct3[0];
            b_sgn = ~funct3[0];
        end else begin
            a_sgn = (funct3[1:0] != 2'b11);
            b_sgn = ~funct3[1];
        end
        a_neg = a_sgn & src_a[WIDTH-1];
        b_neg = b_sgn & src_b[WIDTH-1];
        mag_a = cond_neg(src_a, a_neg);
        mag_b = cond_neg(src_b, b_neg);
    end

    // One radix-2 iteration (shift-add or restoring subtract) plus final sign fix
    always_comb begin
        mul_sum  = {1'b0, eng_hi} + (eng_lo[0] ? {1'b0, eng_m} : {(WIDTH+1){1'b0}});
        div_sh   = {eng_hi, eng_lo[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, eng_m});
        div_diff = div_sh[WIDTH-1:0] - eng_m;
        if (eng_op[2]) begin
            nxt_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
            nxt_lo = {eng_lo[WIDTH-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], eng_lo[WIDTH-1:1]};
        end
        prod = cond_neg2({nxt_hi, nxt_lo}, eng_negq);
        case (eng_op)
            3'b000:          m_res = prod[WIDTH-1:0];
            3'b001, 3'b010,
            3'b011:          m_res = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:  m_res = eng_dz ? {WIDTH{1'b1}} : cond_neg(nxt_lo, eng_negq);
            default:         m_res = eng_dz ? eng_dvd : cond_neg(nxt_hi, eng_negr);
        endcase
        last = (eng_cnt == SHAMT_W'(WIDTH-1));
    end

    // Engine datapath: load on M-op accept, iterate once per CALC cycle
    always_ff @(posedge clk) begin
        if (accept && is_m) begin
            eng_op   <= funct3;
            eng_hi   <= '0;
            eng_m    <= funct3[2] ? mag_b : mag_a;
            eng_lo   <= funct3[2] ? mag_a : mag_b;
            eng_negq <= a_neg ^ b_neg;
            eng_negr <= a_neg;
            eng_dz   <= (src_b == '0);
            eng_dvd  <= src_a;
            eng_cnt  <= '0;
        end else if (state == S_CALC) begin
            eng_hi  <= nxt_hi;
            eng_lo  <= nxt_lo;
            eng_cnt <= eng_cnt + 1'b1;
        end
    end
`endif

    // Handshake FSM and registered result/flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            result   <= '0;
            alu_ctrl <= 4'b0000;
            zero     <= 1'b0;
            illegal  <= 1'b0;
        end else if (accept) begin
`ifdef ALU_EXEC_MDU_EN
            if (is_m) begin
                state    <= S_CALC;
                alu_ctrl <= {1'b1, funct3};
            end else begin
                state    <= S_DONE;
                alu_ctrl <= dec_ctrl;
                result   <= alu_res;
                zero     <= (alu_res == '0);
                illegal  <= 1'b0;
            end
`else
            state <= S_DONE;
            if (is_m) begin
                alu_ctrl <= 4'b1111;
                result   <= '0;
                zero     <= 1'b1;
                illegal  <= 1'b1;
            end else begin
                alu_ctrl <= dec_ctrl;
                result   <= alu_res;
                zero     <= (alu_res == '0);
                illegal  <= 1'b0;
            end
`endif
        end else if ((state == S_DONE) && out_ready) begin
            state <= S_IDLE;
        end
`ifdef ALU_EXEC_MDU_EN
        else if ((state == S_CALC) && last) begin
            state   <= S_DONE;
            result  <= m_res;
            zero    <= (m_res == '0);
            illegal <= 1'b0;
        end
`endif
    end

endmodule
